// File: rtl/isqrt_pkg.sv
// -----------------------------------------------------------------------------
// isqrt_pkg
// Shared definitions for the sequential integer square-root unit:
//   - state_t          : controller states (IDLE / CALC / DONE)
//   - isqrt_rw()       : root width RW for a given operand width
//   - isqrt_n()        : number of CALC clocks N for a width / throughput pair
//   - isqrt_cfg_ok()   : legality of a WIDTH / BITS_PER_CYCLE pair
// -----------------------------------------------------------------------------
package isqrt_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int ISQRT_MIN_WIDTH = 4;
   localparam int ISQRT_MAX_BPC   = 4;

   function automatic int isqrt_rw(input int width);
      return width / 2;
   endfunction

   function automatic int isqrt_n(input int width, input int bpc);
      if (bpc < 1) return 1;
      return (width / 2) / bpc;
   endfunction

   // Width must be even and at least 4; throughput of 1, 2 or 4 root bits per
   // clock, and the root width must split evenly into those groups.
   function automatic bit isqrt_cfg_ok(input int width, input int bpc);
      if (width < ISQRT_MIN_WIDTH)                return 1'b0;
      if ((width % 2) != 0)                       return 1'b0;
      if (!(bpc == 1 || bpc == 2 || bpc == ISQRT_MAX_BPC)) return 1'b0;
      if (((width / 2) % bpc) != 0)               return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/isqrt_step.sv
// -----------------------------------------------------------------------------
// isqrt_step
// One combinational radix-2 non-restoring square-root stage.
// Ports:
//   i_r  : partial remainder in (RW+2 bits, two's complement)
//   i_q  : root bits resolved so far
//   i_d  : next two radicand bits, MSB first
//   o_r  : partial remainder out
//   o_q  : root so far with the new bit appended at the LSB
// -----------------------------------------------------------------------------
module isqrt_step
   import isqrt_pkg::*;
#(
   parameter int RW = 16
) (
   input  logic [RW+1:0] i_r,
   input  logic [RW-1:0] i_q,
   input  logic [1:0]    i_d,
   output logic [RW+1:0] o_r,
   output logic [RW-1:0] o_q
);

   logic [RW+1:0] w_sh;
   logic [RW+1:0] w_t;
   logic          w_neg;

   assign w_neg = i_r[RW+1];

   // The shifted remainder may wrap; the add/subtract result always fits in
   // RW+2 bits, so modular arithmetic gives the exact value.
   assign w_sh = (i_r << 2) | {{RW{1'b0}}, i_d};

   // Negative remainder: add 4q+3, otherwise subtract 4q+1.
   assign w_t  = {i_q, w_neg ? 2'b11 : 2'b01};

   assign o_r  = w_neg ? (w_sh + w_t) : (w_sh - w_t);

   // Before the final stage q holds at most RW-1 significant bits, so the
   // dropped MSB is always zero.
   assign o_q  = {i_q[RW-2:0], ~o_r[RW+1]};

endmodule

// File: rtl/isqrt_seq.sv
// -----------------------------------------------------------------------------
// isqrt_seq
// Sequential integer square root of a signed operand using the non-restoring
// digit-by-digit method, BITS_PER_CYCLE root bits per clock.
// Optional feature macro: ISQRT_ROUND_EN (round-to-nearest root output).
// Ports:
//   i_clk        : clock, rising edge
//   i_rst        : asynchronous active-high reset
//   i_in_valid   : operand valid
//   o_in_ready   : unit can accept an operand (IDLE only)
//   i_x          : signed operand, WIDTH bits
//   i_abort      : cancel in-flight operation (CALC/DONE)
//   o_out_valid  : result valid, held until consumed
//   i_out_ready  : consumer accepts result
//   o_root       : floor root (or rounded root with ISQRT_ROUND_EN)
//   o_rem        : x - floor_root^2
//   o_error      : operand was negative, qualified by o_out_valid
// -----------------------------------------------------------------------------
module isqrt_seq
   import isqrt_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_in_valid,
   output logic                   o_in_ready,
   input  logic [WIDTH-1:0]       i_x,
   input  logic                   i_abort,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [WIDTH/2-1:0]     o_root,
   output logic [WIDTH/2:0]       o_rem,
   output logic                   o_error
);

   localparam int RW = isqrt_rw(WIDTH);
   localparam int N  = isqrt_n(WIDTH, BITS_PER_CYCLE);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int SH = 2 * BITS_PER_CYCLE;

   if (!isqrt_cfg_ok(WIDTH, BITS_PER_CYCLE)) begin : g_cfg_err
      $error("isqrt_seq: illegal WIDTH / BITS_PER_CYCLE combination");
   end

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [WIDTH-1:0] r_rad;
   logic [RW+1:0]   r_prem;
   logic [RW-1:0]   r_q;
   logic [RW-1:0]   r_root;
   logic [RW:0]     r_rem;
   logic            r_err;

   logic            w_accept;
   logic            w_neg;
   logic            w_last;
   logic [RW+1:0]   w_rs;
   logic [RW-1:0]   w_qs;
   logic [RW:0]     w_rem;
   logic [RW-1:0]   w_root;

   assign w_accept = (r_state == S_IDLE) && i_in_valid;
   assign w_neg    = i_x[WIDTH-1];
   assign w_last   = (r_cnt == CW'(N - 1));

   // ---------------------------------------------------------------------------
   // Chain of BITS_PER_CYCLE non-restoring stages, consuming radicand bits from
   // the top of the operand shift register.
   // ---------------------------------------------------------------------------
   for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
      logic [RW+1:0] w_ri;
      logic [RW+1:0] w_ro;
      logic [RW-1:0] w_qi;
      logic [RW-1:0] w_qo;

      if (j == 0) begin : g_first
         assign w_ri = r_prem;
         assign w_qi = r_q;
      end else begin : g_next
         assign w_ri = g_step[j-1].w_ro;
         assign w_qi = g_step[j-1].w_qo;
      end

      isqrt_step #(.RW(RW)) u_step (
         .i_r (w_ri),
         .i_q (w_qi),
         .i_d (r_rad[WIDTH-1-2*j -: 2]),
         .o_r (w_ro),
         .o_q (w_qo)
      );
   end

   assign w_rs = g_step[BITS_PER_CYCLE-1].w_ro;
   assign w_qs = g_step[BITS_PER_CYCLE-1].w_qo;

   // A negative final remainder is corrected by adding back 2q+1; the
   // corrected value is non-negative and fits in RW+1 bits.
   assign w_rem = (RW+1)'(w_rs[RW+1] ? (w_rs + {1'b0, w_qs, 1'b1}) : w_rs);

`ifdef ISQRT_ROUND_EN
   // rem > q means x is past (q+0.5)^2; the rounded root cannot overflow.
   assign w_root = (w_rem > {1'b0, w_qs}) ? (w_qs + RW'(1)) : w_qs;
`else
   assign w_root = w_qs;
`endif

   // ---------------------------------------------------------------------------
   // Controller
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_in_ready = 1'b1;
            if (i_in_valid) w_next = w_neg ? S_DONE : S_CALC;
         end
         S_CALC: begin
            if (i_abort)     w_next = S_IDLE;
            else if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            o_out_valid = 1'b1;
            if (i_abort || i_out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: operand shift register, partial remainder/root, result regs.
   // Results are only written at completion, so they hold through IDLE.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_rad  <= '0;
         r_prem <= '0;
         r_q    <= '0;
         r_root <= '0;
         r_rem  <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_accept) begin
            if (w_neg) begin
               r_root <= '0;
               r_rem  <= '0;
               r_err  <= 1'b1;
            end else begin
               r_rad  <= i_x;
               r_prem <= '0;
               r_q    <= '0;
               r_cnt  <= '0;
            end
         end else if ((r_state == S_CALC) && !i_abort) begin
            r_rad  <= r_rad << SH;
            r_prem <= w_rs;
            r_q    <= w_qs;
            if (w_last) begin
               r_cnt  <= '0;
               r_root <= w_root;
               r_rem  <= w_rem;
               r_err  <= 1'b0;
            end else begin
               r_cnt  <= r_cnt + CW'(1);
            end
         end
      end
   end

   assign o_root  = r_root;
   assign o_rem   = r_rem;
   assign o_error = r_err;

endmodule

// File: tb/tb_isqrt_seq.sv
// -----------------------------------------------------------------------------
// tb_isqrt_seq
// Three isqrt_seq instances (WIDTH=32, BITS_PER_CYCLE = 1, 2, 4). Expected
// results are pushed to a per-instance queue on acceptance and compared when
// the instance hands out a result. Instance 2 also runs a random sweep under
// random out_ready back-pressure.
// -----------------------------------------------------------------------------
module tb_isqrt_seq;

   typedef struct {
      logic [31:0] x;
      logic [15:0] root;
      logic [16:0] rem;
      logic        err;
   } exp_t;

`ifdef ISQRT_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic        clk, rst;
   logic [2:0]  iv, ir, ab, ordy, w_ordy, ov, er;
   logic [31:0] xv [3];
   logic [15:0] rt [3];
   logic [16:0] rm [3];
   logic        bp_en, bp_rdy;

   exp_t        sbq [3][$];
   int          n_chk, n_pass;
   int          n_out [3];

   assign w_ordy = {(bp_en ? bp_rdy : ordy[2]), ordy[1:0]};

   for (genvar k = 0; k < 3; k++) begin : g_dut
      isqrt_seq #(.WIDTH(32), .BITS_PER_CYCLE(1 << k)) u_dut (
         .i_clk       (clk),
         .i_rst       (rst),
         .i_in_valid  (iv[k]),
         .o_in_ready  (ir[k]),
         .i_x         (xv[k]),
         .i_abort     (ab[k]),
         .o_out_valid (ov[k]),
         .i_out_ready (w_ordy[k]),
         .o_root      (rt[k]),
         .o_rem       (rm[k]),
         .o_error     (er[k])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Reference: floating-point estimate refined to the exact floor root.
   function automatic exp_t model(input logic [31:0] xin);
      exp_t   e;
      longint v, r;
      e.x = xin;
      if (xin[31]) begin
         e.root = '0; e.rem = '0; e.err = 1'b1;
         return e;
      end
      v = longint'(xin);
      r = longint'($rtoi($sqrt(real'(v))));
      while (r * r > v) r--;
      while ((r + 1) * (r + 1) <= v) r++;
      e.err  = 1'b0;
      e.rem  = 17'(v - r * r);
      e.root = 16'((RND && (v - r * r) > r) ? r + 1 : r);
      return e;
   endfunction

   // Scoreboard: push on acceptance, pop and compare on result consumption.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            if (iv[k] && ir[k]) sbq[k].push_back(model(xv[k]));
            if (ov[k] && w_ordy[k] && !ab[k]) begin
               n_out[k]++;
               chk("sb_nonempty", longint'(sbq[k].size() > 0), 1);
               if (sbq[k].size() > 0) begin
                  exp_t e;
                  e = sbq[k].pop_front();
                  chk("root", rt[k], e.root);
                  chk("rem",  rm[k], e.rem);
                  chk("err",  er[k], e.err);
`ifndef ISQRT_ROUND_EN
                  if (!e.err) begin
                     chk("ident", longint'(rt[k]) * longint'(rt[k]) + longint'(rm[k]), longint'(e.x));
                     chk("rem_bound", longint'(longint'(rm[k]) <= 2 * longint'(rt[k])), 1);
                  end
`endif
               end
            end
         end
      end
   end

   initial begin
      bp_rdy = 1'b1;
      forever begin
         @(posedge clk); #1;
         bp_rdy = ($urandom_range(0, 3) != 0);
      end
   end

   // Called and returns at posedge+1; the accept edge is the posedge in between.
   task automatic send(input int k, input logic [31:0] xin);
      int t;
      t = 0;
      while (!ir[k] && t < 200) begin
         @(posedge clk); #1; t++;
      end
      if (t == 200) chk("send_timeout", t, 0);
      xv[k] = xin;
      iv[k] = 1'b1;
      @(posedge clk); #1;
      iv[k] = 1'b0;
   endtask

   task automatic run_lat(input int k, input logic [31:0] xin, input int exp_lat);
      int lat;
      send(k, xin);
      lat = 0;
      do begin
         @(negedge clk); lat++;
      end while (!ov[k] && lat < 100);
      chk("latency", lat, exp_lat);
      @(posedge clk); #1;
   endtask

   initial begin
      int t, outs0;
      n_chk = 0; n_pass = 0;
      rst = 1'b1; iv = '0; ab = '0; ordy = '1; bp_en = 1'b0;
      for (int k = 0; k < 3; k++) begin xv[k] = '0; n_out[k] = 0; end

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", ir[0], 1);
      chk("rst_out_valid", ov[0], 0);
      chk("rst_root", rt[0], 0);
      chk("rst_rem", rm[0], 0);
      chk("rst_error", er[0], 0);

      run_lat(0, 32'd1000000, 17);
      chk("r1e6_root", rt[0], 1000);
      chk("r1e6_rem", rm[0], 0);

      for (int k = 0; k < 3; k++) begin
         run_lat(k, 32'd2147483647, 16 / (1 << k) + 1);
         chk("max_root", rt[k], RND ? 46341 : 46340);
         chk("max_rem", rm[k], 88047);
      end

      run_lat(0, -32'sd5, 1);
      chk("neg_root", rt[0], 0);
      chk("neg_rem", rm[0], 0);
      chk("neg_err", er[0], 1);
      run_lat(0, 32'd0, 17);
      chk("zero_root", rt[0], 0);
      chk("zero_err", er[0], 0);

      // Back-pressure: result must hold while out_ready is low.
      ordy[0] = 1'b0;
      send(0, 32'd8);
      t = 0;
      while (!ov[0] && t < 40) begin @(negedge clk); t++; end
      chk("hold_reached", ov[0], 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_valid", ov[0], 1);
         chk("hold_in_ready", ir[0], 0);
         chk("hold_root", rt[0], RND ? 3 : 2);
         chk("hold_rem", rm[0], 4);
      end
      @(posedge clk); #1 ordy[0] = 1'b1;
      @(posedge clk); #1;
      chk("release_in_ready", ir[0], 1);
      chk("release_out_valid", ov[0], 0);

      // Abort during step 5 of x=81, then x=99 must be the only result.
      outs0 = n_out[0];
      send(0, 32'd81);
      repeat (5) begin @(posedge clk); #1; end
      ab[0] = 1'b1;
      @(posedge clk); #1 ab[0] = 1'b0;
      chk("abort_out_valid", ov[0], 0);
      chk("abort_in_ready", ir[0], 1);
      sbq[0].delete();
      run_lat(0, 32'd99, 17);
      chk("abort_one_out", n_out[0] - outs0, 1);
      chk("r99_root", rt[0], RND ? 10 : 9);
      chk("r99_rem", rm[0], 18);

      // Reset mid-CALC discards the operand and clears outputs.
      send(0, 32'd1000000);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      chk("mrst_in_ready", ir[0], 1);
      chk("mrst_out_valid", ov[0], 0);
      chk("mrst_root", rt[0], 0);
      chk("mrst_rem", rm[0], 0);
      chk("mrst_error", er[0], 0);
      @(posedge clk); #1 rst = 1'b0;
      sbq[0].delete();

      // Random sweep with back-pressure on the 4-bit-per-cycle instance.
      bp_en = 1'b1;
      send(2, 32'd0);
      send(2, 32'd1);
      send(2, 32'h7fffffff);
      send(2, 32'h80000000);
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] xr;
         xr = $urandom();
         if ((i % 8) != 0) xr[31] = 1'b0;
         if ((i % 16) == 3) xr = xr & 32'h000000ff;
         send(2, xr);
      end
      t = 0;
      while (sbq[2].size() != 0 && t < 2000) begin @(posedge clk); #1; t++; end
      chk("drain2", sbq[2].size(), 0);
      chk("drain0", sbq[0].size(), 0);
      chk("drain1", sbq[1].size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
